// File: rtl/console_pkg.sv
// console_pkg -- shared constants and FSM state type for the text console.
//
// Holds the screen geometry (COLS/ROWS), the fill character, the control
// codes the console interprets, the byte counts of the video RAM and the
// state enum used by text_console.
//
// Build option: CONSOLE_SCROLL_EN adds the scroll states to the enum.
package console_pkg;

  localparam int         COLS  = 80;
  localparam int         ROWS  = 25;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  localparam int SCROLL_BYTES = 3840;
  localparam int SCREEN_BYTES = 4000;

  // CTRL is the single busy cycle spent on CR, LF and BS.
  typedef enum logic [2:0] {
    IDLE,
    PUT_CHR,
    PUT_ATR,
    CTRL,
    CLS
`ifdef CONSOLE_SCROLL_EN
    ,
    SCR_RD,
    SCR_WR,
    SCR_CLR
`endif
  } state_t;

endpackage

// File: rtl/console_pos.sv
// console_pos -- row/column tracker and registered cursor for text_console.
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   adv            : advance one cell (wraps to next row at the last column)
//   lf             : next row, column kept
//   cr             : column 0
//   bs             : column - 1, stays at column 0
//   home           : row = column = 0
//   cursor         : registered row*COLS+col
//   eos            : cursor is on the last row
//   col_last       : cursor is on the last column
//
// Build option: CONSOLE_SCROLL_EN keeps the row at the last row when the
// screen end is crossed (the caller scrolls); otherwise the row wraps to 0.
module console_pos #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        adv,
  input  logic        lf,
  input  logic        cr,
  input  logic        bs,
  input  logic        home,
  output logic [10:0] cursor,
  output logic        eos,
  output logic        col_last
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
`ifdef CONSOLE_SCROLL_EN
  localparam logic [4:0] WRAP_ROW = LAST_ROW;
`else
  localparam logic [4:0] WRAP_ROW = 5'd0;
`endif

  logic [4:0]  row_reg, row_next;
  logic [6:0]  col_reg, col_next;
  logic [10:0] cursor_reg;

  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (home) begin
      row_next = 5'd0;
      col_next = 7'd0;
    end else if (cr) begin
      col_next = 7'd0;
    end else if (bs) begin
      if (col_reg != 7'd0) col_next = col_reg - 7'd1;
    end else if (adv) begin
      if (col_reg == LAST_COL) begin
        col_next = 7'd0;
        row_next = (row_reg == LAST_ROW) ? WRAP_ROW : row_reg + 5'd1;
      end else begin
        col_next = col_reg + 7'd1;
      end
    end else if (lf) begin
      row_next = (row_reg == LAST_ROW) ? WRAP_ROW : row_reg + 5'd1;
    end
  end

  // The cursor is computed from the next position so it moves on the
  // same edge as row/col.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_reg    <= 5'd0;
      col_reg    <= 7'd0;
      cursor_reg <= 11'd0;
    end else begin
      row_reg    <= row_next;
      col_reg    <= col_next;
      cursor_reg <= 11'(row_next) * 11'(COLS) + 11'(col_next);
    end
  end

  assign cursor   = cursor_reg;
  assign eos      = (row_reg == LAST_ROW);
  assign col_last = (col_reg == LAST_COL);

endmodule

// File: rtl/text_console.sv
// text_console -- character-stream writer for the 80x25 text video RAM.
//
// Accepts a byte plus attribute over valid/ready, writes char/attr pairs to
// even/odd RAM bytes and handles CR, LF, BS and FF (clear screen).
//
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   in_data/in_attr       : byte and attribute, taken when in_valid && in_ready
//   in_ready              : high only while idle
//   mem_address/wdata/we  : video RAM write port (one byte per cycle)
//   mem_rdata             : synchronous RAM read data, one cycle after address
//   cursor                : cell index row*COLS+col
//   busy                  : an operation is in progress
//
// Build option: CONSOLE_SCROLL_EN -- at the end of the screen the contents
// are scrolled up one row by block copy and the last row is blanked;
// without it the row wraps to 0 and no memory is touched.
module text_console #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 25,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_attr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [10:0] cursor,
  output logic        busy
);

  import console_pkg::*;

  localparam logic [11:0] LAST_BYTE = 12'(2 * COLS * ROWS - 1);
`ifdef CONSOLE_SCROLL_EN
  localparam logic [11:0] ROW_BYTES = 12'(2 * COLS);
  localparam logic [11:0] LAST_COPY = 12'(2 * COLS * (ROWS - 1) - 1);
`endif

  state_t      state_reg;
  logic [7:0]  data_q, attr_q, wdata_reg;
  logic [11:0] addr_reg;
  logic        we_reg;

  logic        adv, lf, cr, bs, home, eos, col_last, at_last, scroll_go;

  assign at_last = (addr_reg == LAST_BYTE);
  assign cr      = (state_reg == CTRL) && (data_q == CC_CR);
  assign bs      = (state_reg == CTRL) && (data_q == CC_BS);
  assign home    = (state_reg == CLS) && at_last;

`ifdef CONSOLE_SCROLL_EN
  // End of screen: a printable in the last cell or LF on the last row.
  assign scroll_go = ((state_reg == PUT_ATR) && eos && col_last) ||
                     ((state_reg == CTRL) && eos && (data_q == CC_LF));
  // A scrolled operation moves the position only when the clear finishes.
  assign adv = ((state_reg == PUT_ATR) && !scroll_go) ||
               ((state_reg == SCR_CLR) && at_last && (data_q != CC_LF));
  assign lf  = ((state_reg == CTRL) && (data_q == CC_LF) && !scroll_go) ||
               ((state_reg == SCR_CLR) && at_last && (data_q == CC_LF));
  // Copy data comes straight from the RAM read port during SCR_WR.
  assign mem_wdata = (state_reg == SCR_WR) ? mem_rdata : wdata_reg;
`else
  logic unused_ok;
  assign scroll_go = 1'b0;
  assign adv       = (state_reg == PUT_ATR);
  assign lf        = (state_reg == CTRL) && (data_q == CC_LF);
  assign mem_wdata = wdata_reg;
  assign unused_ok = ^{eos, col_last, mem_rdata, scroll_go};
`endif

  console_pos #(.COLS(COLS), .ROWS(ROWS)) u_pos (
    .clock    (clock),
    .reset_n  (reset_n),
    .adv      (adv),
    .lf       (lf),
    .cr       (cr),
    .bs       (bs),
    .home     (home),
    .cursor   (cursor),
    .eos      (eos),
    .col_last (col_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      data_q    <= 8'h00;
      attr_q    <= 8'h00;
      wdata_reg <= 8'h00;
      addr_reg  <= 12'd0;
      we_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            attr_q <= in_attr;
            case (in_data)
              CC_FF: begin
                state_reg <= CLS;
                we_reg    <= 1'b1;
                addr_reg  <= 12'd0;
                wdata_reg <= BLANK;
              end
              CC_CR, CC_LF, CC_BS: state_reg <= CTRL;
              default: begin
                state_reg <= PUT_CHR;
                we_reg    <= 1'b1;
                addr_reg  <= {cursor, 1'b0};
                wdata_reg <= in_data;
              end
            endcase
          end
        end
        PUT_CHR: begin
          state_reg <= PUT_ATR;
          addr_reg  <= addr_reg + 12'd1;
          wdata_reg <= attr_q;
        end
        PUT_ATR, CTRL: begin
          we_reg    <= 1'b0;
          state_reg <= IDLE;
`ifdef CONSOLE_SCROLL_EN
          if (scroll_go) begin
            state_reg <= SCR_RD;
            addr_reg  <= ROW_BYTES;
          end
`endif
        end
`ifdef CONSOLE_SCROLL_EN
        SCR_RD: begin
          state_reg <= SCR_WR;
          we_reg    <= 1'b1;
          addr_reg  <= addr_reg - ROW_BYTES;
        end
        SCR_WR: begin
          if (addr_reg == LAST_COPY) begin
            state_reg <= SCR_CLR;
            addr_reg  <= LAST_COPY + 12'd1;
            wdata_reg <= BLANK;
          end else begin
            state_reg <= SCR_RD;
            we_reg    <= 1'b0;
            addr_reg  <= addr_reg + ROW_BYTES + 12'd1;
          end
        end
        SCR_CLR,
`endif
        CLS: begin
          if (at_last) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
          end else begin
            addr_reg  <= addr_reg + 12'd1;
            // Next address is odd when the current one is even.
            wdata_reg <= addr_reg[0] ? BLANK : attr_q;
          end
        end
        default: begin
          state_reg <= IDLE;
          we_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address = addr_reg;
  assign mem_we      = we_reg;
  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_text_console.sv
// Testbench for text_console: synchronous RAM model plus a screen-level
// reference model (character grid, cursor row/col, expected busy and write
// counts per byte). Works with and without CONSOLE_SCROLL_EN.
module tb_text_console;
  import console_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h00;
  logic [10:0] cursor;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int tx_num = 0;

  text_console dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_attr     (in_attr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .cursor      (cursor),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Video RAM: write and registered read on the same edge.
  logic [7:0] ram [0:4095];
  always @(posedge clock) begin
    if (mem_we) ram[mem_address] <= mem_wdata;
    mem_rdata <= ram[mem_address];
  end

  // Reference model of the screen.
  logic [7:0] m_mem [0:SCREEN_BYTES-1];
  int m_row = 0;
  int m_col = 0;
  int exp_busy;
  int exp_we;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic m_end_of_screen(input logic [7:0] a);
`ifdef CONSOLE_SCROLL_EN
    for (int i = 0; i < SCROLL_BYTES; i++) m_mem[i] = m_mem[i + 2*COLS];
    for (int i = SCROLL_BYTES; i < SCREEN_BYTES; i++) m_mem[i] = (i % 2 == 1) ? a : BLANK;
    exp_busy += 2 * SCROLL_BYTES + (SCREEN_BYTES - SCROLL_BYTES);
    exp_we   += SCREEN_BYTES;
`else
    m_row = 0;
`endif
  endtask

  task automatic m_apply(input logic [7:0] d, input logic [7:0] a);
    int idx;
    exp_busy = 0;
    exp_we   = 0;
    case (d)
      CC_CR: begin m_col = 0; exp_busy = 1; end
      CC_BS: begin if (m_col > 0) m_col--; exp_busy = 1; end
      CC_LF: begin
        exp_busy = 1;
        if (m_row == ROWS-1) m_end_of_screen(a);
        else m_row++;
      end
      CC_FF: begin
        for (int i = 0; i < SCREEN_BYTES; i++) m_mem[i] = (i % 2 == 1) ? a : BLANK;
        m_row = 0; m_col = 0;
        exp_busy = SCREEN_BYTES;
        exp_we = SCREEN_BYTES;
      end
      default: begin
        idx = m_row * COLS + m_col;
        m_mem[2*idx]   = d;
        m_mem[2*idx+1] = a;
        exp_busy = 2;
        exp_we = 2;
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          if (m_row == ROWS-1) m_end_of_screen(a);
          else m_row++;
        end
      end
    endcase
  endtask

  // Drive one byte; keep in_valid high with junk data while busy to prove
  // held bytes are ignored. Starts and ends at a negedge.
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int bcnt;
    int wcnt;
    m_apply(d, a);
    tx_num++;
    check_eq("ready", in_ready, 1);
    in_data = d; in_attr = a; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bcnt = 0; wcnt = 0;
    while (busy && bcnt < 20000) begin
      bcnt++;
      if (mem_we) wcnt++;
      in_data = 8'($urandom);
      @(negedge clock);
    end
    in_valid = 1'b0;
    check_eq("busy_cycles", bcnt, exp_busy);
    check_eq("write_count", wcnt, exp_we);
    check_eq("we_idle", mem_we, 0);
    check_eq("cursor", cursor, m_row * COLS + m_col);
    $display("tx %0d data=%02h attr=%02h cursor=%0d busy=%0d writes=%0d",
             tx_num, d, a, cursor, bcnt, wcnt);
  endtask

  task automatic check_mem(input string tag);
    int nmis;
    int first;
    nmis = 0; first = -1;
    for (int i = 0; i < SCREEN_BYTES; i++) begin
      if (ram[i] !== m_mem[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
    end
    check_eq($sformatf("%s_mem_mismatches(first=%0d)", tag, first), nmis, 0);
  endtask

  function automatic logic [7:0] rand_prn();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255));
    while (c == CC_BS || c == CC_LF || c == CC_FF || c == CC_CR);
    return c;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    for (int i = 0; i < SCREEN_BYTES; i++) m_mem[i] = 8'h00;

    // Reset state.
    repeat (2) @(negedge clock);
    check_eq("rst_cursor", cursor, 0);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_address, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // First character.
    send(8'h41, 8'h1F);
    check_eq("A_char", ram[0], 8'h41);
    check_eq("A_attr", ram[1], 8'h1F);
    check_eq("A_cursor", cursor, 1);

    // CR / LF from cursor 5.
    for (int i = 0; i < 4; i++) send(rand_prn(), 8'($urandom));
    check_eq("pre_cr_cursor", cursor, 5);
    send(CC_CR, 8'h07);
    check_eq("cr_cursor", cursor, 0);
    send(CC_LF, 8'h07);
    check_eq("lf_cursor", cursor, 80);
    check_mem("crlf");

    // Clear screen.
    send(CC_FF, 8'h07);
    check_eq("ff_cursor", cursor, 0);
    check_mem("ff");

    // Backspace at column 0 and mid-row.
    send(CC_BS, 8'h07);
    check_eq("bs0_cursor", cursor, 0);
    send(CC_LF, 8'h07);
    send(8'h78, 8'h07);
    check_eq("pre_bs_cursor", cursor, 81);
    send(CC_BS, 8'h07);
    check_eq("bs81_cursor", cursor, 80);
    check_mem("bs");

    // Reset in the middle of a clear.
    check_eq("ready", in_ready, 1);
    in_data = CC_FF; in_attr = 8'h4E; in_valid = 1'b1;
    n = 0;
    @(posedge clock);
    repeat (100) begin
      @(negedge clock);
      if (mem_we) n++;
      in_valid = 1'b0;
      @(posedge clock);
    end
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_we", mem_we, 0);
    check_eq("abort_cursor", cursor, 0);
    check_eq("abort_busy", busy, 0);
    for (int i = 0; i < n; i++) m_mem[i] = (i % 2 == 1) ? 8'h4E : BLANK;
    m_row = 0; m_col = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("abort_writes", n, 100);
    check_mem("abort");

    // Random traffic.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       send(CC_FF, 8'($urandom));
      else if (r < 7)  send(CC_LF, 8'($urandom));
      else if (r < 11) send(CC_CR, 8'($urandom));
      else if (r < 15) send(CC_BS, 8'($urandom));
      else             send(rand_prn(), 8'($urandom));
      if (k % 50 == 49) check_mem("random");
    end

    // Full-screen fill: the 2000th character hits the end of the screen.
    send(CC_FF, 8'h07);
    for (int k = 0; k < COLS * ROWS; k++) send(rand_prn(), 8'($urandom));
`ifdef CONSOLE_SCROLL_EN
    check_eq("fill_cursor", cursor, 1920);
    check_eq("fill_last_busy", exp_busy, 2 + 7840);
`else
    check_eq("fill_cursor", cursor, 0);
`endif
    check_mem("fill");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
